mem_arbiter: RTL and testbench

//  Shares the single unified memory port between the MIPS core (cpu_*) and a

---
 rtl/mem_arbiter_if.sv | 64 ++++++
 rtl/mem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the two requester ports (cpu_*, ldr_*) and the
// unified memory port (mem_*) of mem_arbiter.
//
// Modports
//   slave  : the arbiter's view. Takes requests from cpu/ldr and returns
//            rdata/ready. Drives the memory address/data/strobe and takes
//            mem_rdata.
//   master : the environment's view (core, loader, memory model).
//
// Signals
//   cpu_req/ldr_req            request, level
//   cpu_adr/ldr_adr      [N]   request address
//   cpu_wdata/ldr_wdata  [N]   request write data
//   cpu_memwrite/...     [2]   00 = read, nonzero = write code
//   cpu_dtype/ldr_dtype        access size
//   cpu_rdata/ldr_rdata  [N]   registered read data per requester
//   cpu_ready/ldr_ready        one-cycle completion pulse
//   mem_adr/mem_wdata    [N]   memory address / write data
//   mem_memwrite         [2]   memory write strobe code
//   mem_dtype                  memory access size
//   mem_rdata            [N]   memory read data
interface mem_arbiter_if #(
   parameter int unsigned N = 64
);
   logic         cpu_req;
   logic [N-1:0] cpu_adr;
   logic [N-1:0] cpu_wdata;
   logic [1:0]   cpu_memwrite;
   logic         cpu_dtype;
   logic [N-1:0] cpu_rdata;
   logic         cpu_ready;

   logic         ldr_req;
   logic [N-1:0] ldr_adr;
   logic [N-1:0] ldr_wdata;
   logic [1:0]   ldr_memwrite;
   logic         ldr_dtype;
   logic [N-1:0] ldr_rdata;
   logic         ldr_ready;

   logic [N-1:0] mem_adr;
   logic [N-1:0] mem_wdata;
   logic [1:0]   mem_memwrite;
   logic         mem_dtype;
   logic [N-1:0] mem_rdata;

   modport slave (
      input  cpu_req, cpu_adr, cpu_wdata, cpu_memwrite, cpu_dtype,
      output cpu_rdata, cpu_ready,
      input  ldr_req, ldr_adr, ldr_wdata, ldr_memwrite, ldr_dtype,
      output ldr_rdata, ldr_ready,
      output mem_adr, mem_wdata, mem_memwrite, mem_dtype,
      input  mem_rdata
   );

   modport master (
      output cpu_req, cpu_adr, cpu_wdata, cpu_memwrite, cpu_dtype,
      input  cpu_rdata, cpu_ready,
      output ldr_req, ldr_adr, ldr_wdata, ldr_memwrite, ldr_dtype,
      input  ldr_rdata, ldr_ready,
      input  mem_adr, mem_wdata, mem_memwrite, mem_dtype,
      output mem_rdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single unified memory port between the MIPS core
// (cpu_*) and the program loader / debug master (ldr_*). One transaction is
// accepted at a time, its request fields are latched, the memory is driven
// for the duration of the access and ready/read data go back to the
// requester that issued it.
//
// Parameters
//   N        data and address width
//   MEM_LAT  memory read latency in cycles, legal range 1..7
//
// Ports
//   clk    clock, all logic on the rising edge
//   reset  synchronous, active-high reset
//   bus    mem_arbiter_if.slave: cpu_*, ldr_* requester ports and mem_* port
//   busy   high whenever the FSM is not idle
//   owner  last granted requester, 0 = cpu, 1 = ldr
//
// Configuration
//   MEM_ARB_CPU_PRIO_EN  when defined, cpu wins every tie (fixed priority);
//                        otherwise ties are resolved round-robin.
module mem_arbiter #(
   parameter int unsigned N       = 64,
   parameter int unsigned MEM_LAT = 1
) (
   input  logic         clk,
   input  logic         reset,
   mem_arbiter_if.slave bus,
   output logic         busy,
   output logic         owner
);

   typedef enum logic [1:0] {
      s_idle,
      s_access,
      s_wait,
      s_resp
   } state_e;

   // WAIT lasts MEM_LAT cycles; rdata is captured in the last one
   localparam logic [2:0] CntLoad = 3'(MEM_LAT - 1);

   state_e       state_q, state_d;
   logic [N-1:0] adr_q, adr_d;
   logic [N-1:0] wdata_q, wdata_d;
   logic [1:0]   memwrite_q, memwrite_d;
   logic         dtype_q, dtype_d;
   logic         owner_q, owner_d;
   logic [2:0]   cnt_q, cnt_d;
   logic [N-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [N-1:0] ldr_rdata_q, ldr_rdata_d;

   logic         any_req;
   logic         grant_ldr;

   assign any_req = bus.cpu_req | bus.ldr_req;

   // grant_ldr is only consulted when any_req is high
`ifdef MEM_ARB_CPU_PRIO_EN
   assign grant_ldr = ~bus.cpu_req;
`else
   // On a tie the requester that did not own the last grant wins
   assign grant_ldr = bus.ldr_req & (~bus.cpu_req | ~owner_q);
`endif

   always_comb begin
      state_d     = state_q;
      adr_d       = adr_q;
      wdata_d     = wdata_q;
      memwrite_d  = memwrite_q;
      dtype_d     = dtype_q;
      owner_d     = owner_q;
      cnt_d       = cnt_q;
      cpu_rdata_d = cpu_rdata_q;
      ldr_rdata_d = ldr_rdata_q;

      unique case (state_q)
         s_idle: begin
            if (any_req) begin
               state_d = s_access;
               owner_d = grant_ldr;
               if (grant_ldr) begin
                  adr_d      = bus.ldr_adr;
                  wdata_d    = bus.ldr_wdata;
                  memwrite_d = bus.ldr_memwrite;
                  dtype_d    = bus.ldr_dtype;
               end else begin
                  adr_d      = bus.cpu_adr;
                  wdata_d    = bus.cpu_wdata;
                  memwrite_d = bus.cpu_memwrite;
                  dtype_d    = bus.cpu_dtype;
               end
            end
         end

         s_access: begin
            if (memwrite_q != 2'b00) begin
               state_d = s_resp;
            end else begin
               cnt_d   = CntLoad;
               state_d = s_wait;
            end
         end

         s_wait: begin
            if (cnt_q == 3'd0) begin
               state_d = s_resp;
               if (owner_q) begin
                  ldr_rdata_d = bus.mem_rdata;
               end else begin
                  cpu_rdata_d = bus.mem_rdata;
               end
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end

         s_resp: begin
            state_d = s_idle;
         end

         default: begin
            state_d = s_idle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= s_idle;
         adr_q       <= '0;
         wdata_q     <= '0;
         memwrite_q  <= 2'b00;
         dtype_q     <= 1'b0;
         owner_q     <= 1'b1;
         cnt_q       <= 3'd0;
         cpu_rdata_q <= '0;
         ldr_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         adr_q       <= adr_d;
         wdata_q     <= wdata_d;
         memwrite_q  <= memwrite_d;
         dtype_q     <= dtype_d;
         owner_q     <= owner_d;
         cnt_q       <= cnt_d;
         cpu_rdata_q <= cpu_rdata_d;
         ldr_rdata_q <= ldr_rdata_d;
      end
   end

   // Address/data/size hold the last latched request, also through idle
   assign bus.mem_adr      = adr_q;
   assign bus.mem_wdata    = wdata_q;
   assign bus.mem_dtype    = dtype_q;
   // Strobe only during the single access cycle; reads latch code 00
   assign bus.mem_memwrite = (state_q == s_access) ? memwrite_q : 2'b00;

   assign bus.cpu_ready = (state_q == s_resp) & ~owner_q;
   assign bus.ldr_ready = (state_q == s_resp) & owner_q;
   assign bus.cpu_rdata = cpu_rdata_q;
   assign bus.ldr_rdata = ldr_rdata_q;

   assign busy  = (state_q != s_idle);
   assign owner = owner_q;

`ifndef SYNTHESIS
   a_one_ready : assert property (@(posedge clk) disable iff (reset)
      !(bus.cpu_ready && bus.ldr_ready));
   a_ready_in_resp : assert property (@(posedge clk) disable iff (reset)
      (bus.cpu_ready || bus.ldr_ready) |-> (state_q == s_resp));
   a_strobe_in_access : assert property (@(posedge clk) disable iff (reset)
      (bus.mem_memwrite != 2'b00) |-> (state_q == s_access));
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter. Two instances are built, one with MEM_LAT = 1 and
// one with MEM_LAT = 3; sel picks which one is active while the other is held
// in reset. A small associative-array memory with a read pipeline serves the
// active instance. Expected grants, timing and read data come from a
// transaction-level model kept in the bench.
module tb_mem_arbiter;
   localparam int unsigned N = 64;

   logic clk = 1'b0;
   logic reset;
   logic sel;
   logic rst1, rst3;

   always #5 clk = ~clk;

   assign rst1 = reset | sel;
   assign rst3 = reset | ~sel;

   logic         cpu_req, ldr_req;
   logic [N-1:0] cpu_adr, cpu_wdata, ldr_adr, ldr_wdata;
   logic [1:0]   cpu_memwrite, ldr_memwrite;
   logic         cpu_dtype, ldr_dtype;

   mem_arbiter_if #(.N(N)) bus1 ();
   mem_arbiter_if #(.N(N)) bus3 ();
   logic busy1, owner1, busy3, owner3;

   mem_arbiter #(.N(N), .MEM_LAT(1)) u_dut1 (
      .clk   (clk),
      .reset (rst1),
      .bus   (bus1),
      .busy  (busy1),
      .owner (owner1)
   );

   mem_arbiter #(.N(N), .MEM_LAT(3)) u_dut3 (
      .clk   (clk),
      .reset (rst3),
      .bus   (bus3),
      .busy  (busy3),
      .owner (owner3)
   );

   assign bus1.cpu_req = cpu_req;           assign bus3.cpu_req = cpu_req;
   assign bus1.cpu_adr = cpu_adr;           assign bus3.cpu_adr = cpu_adr;
   assign bus1.cpu_wdata = cpu_wdata;       assign bus3.cpu_wdata = cpu_wdata;
   assign bus1.cpu_memwrite = cpu_memwrite; assign bus3.cpu_memwrite = cpu_memwrite;
   assign bus1.cpu_dtype = cpu_dtype;       assign bus3.cpu_dtype = cpu_dtype;
   assign bus1.ldr_req = ldr_req;           assign bus3.ldr_req = ldr_req;
   assign bus1.ldr_adr = ldr_adr;           assign bus3.ldr_adr = ldr_adr;
   assign bus1.ldr_wdata = ldr_wdata;       assign bus3.ldr_wdata = ldr_wdata;
   assign bus1.ldr_memwrite = ldr_memwrite; assign bus3.ldr_memwrite = ldr_memwrite;
   assign bus1.ldr_dtype = ldr_dtype;       assign bus3.ldr_dtype = ldr_dtype;

   // Observed outputs of the active instance
   logic         o_busy, o_owner, o_cpu_ready, o_ldr_ready, o_mem_dtype;
   logic [N-1:0] o_cpu_rdata, o_ldr_rdata, o_mem_adr, o_mem_wdata;
   logic [1:0]   o_mem_memwrite;

   assign o_busy         = sel ? busy3 : busy1;
   assign o_owner        = sel ? owner3 : owner1;
   assign o_cpu_ready    = sel ? bus3.cpu_ready : bus1.cpu_ready;
   assign o_ldr_ready    = sel ? bus3.ldr_ready : bus1.ldr_ready;
   assign o_cpu_rdata    = sel ? bus3.cpu_rdata : bus1.cpu_rdata;
   assign o_ldr_rdata    = sel ? bus3.ldr_rdata : bus1.ldr_rdata;
   assign o_mem_adr      = sel ? bus3.mem_adr : bus1.mem_adr;
   assign o_mem_wdata    = sel ? bus3.mem_wdata : bus1.mem_wdata;
   assign o_mem_memwrite = sel ? bus3.mem_memwrite : bus1.mem_memwrite;
   assign o_mem_dtype    = sel ? bus3.mem_dtype : bus1.mem_dtype;

   // Memory model: data appears MEM_LAT cycles after the address
   logic [N-1:0] mem_arr [logic [N-1:0]];
   logic [N-1:0] pipe [3];

   function automatic logic [N-1:0] mem_rd(input logic [N-1:0] a);
      if (mem_arr.exists(a)) return mem_arr[a];
      return {a[31:0] ^ 32'hC0FF_EE11, ~a[31:0]};
   endfunction

   always @(posedge clk) begin
      pipe[0] <= mem_rd(o_mem_adr);
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
      if (o_mem_memwrite != 2'b00) mem_arr[o_mem_adr] = o_mem_wdata;
   end

   assign bus1.mem_rdata = pipe[0];
   assign bus3.mem_rdata = pipe[2];

   // Reference model state
   int           checks = 0;
   int           errors = 0;
   int           lat;
   bit           m_owner;
   logic [N-1:0] exp_cpu, exp_ldr;

   function automatic logic [N-1:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   // One transaction, entered at the falling edge of an idle cycle.
   task automatic do_txn(input string tag, input bit creq, input bit lreq,
                         input logic [N-1:0] c_adr, input logic [N-1:0] c_wd,
                         input logic [1:0] c_mw, input logic c_dt,
                         input logic [N-1:0] l_adr, input logic [N-1:0] l_wd,
                         input logic [1:0] l_mw, input logic l_dt,
                         input bit hold, output bit obs_owner);
      bit           g, rd;
      logic [N-1:0] a, wd, rd_exp;
      logic [1:0]   mw;
      logic         dt;
      logic [5:0]   st_got, st_exp;

      st_got = {o_busy, o_owner, o_cpu_ready, o_ldr_ready, o_mem_memwrite};
      st_exp = {1'b0, m_owner, 4'b0000};
      checks++;
      if (st_got !== st_exp) begin
         errors++;
         $display("FAIL %s idle status got %b exp %b", tag, st_got, st_exp);
      end

      cpu_req = creq; cpu_adr = c_adr; cpu_wdata = c_wd;
      cpu_memwrite = c_mw; cpu_dtype = c_dt;
      ldr_req = lreq; ldr_adr = l_adr; ldr_wdata = l_wd;
      ldr_memwrite = l_mw; ldr_dtype = l_dt;

`ifdef MEM_ARB_CPU_PRIO_EN
      g = !creq;
`else
      g = lreq && (!creq || !m_owner);
`endif
      a  = g ? l_adr : c_adr;
      wd = g ? l_wd : c_wd;
      mw = g ? l_mw : c_mw;
      dt = g ? l_dt : c_dt;
      rd = (mw == 2'b00);
      m_owner = g;

      @(negedge clk);  // access cycle
      obs_owner = o_owner;
      st_got = {o_busy, o_owner, o_cpu_ready, o_ldr_ready, o_mem_memwrite};
      st_exp = {1'b1, g, 2'b00, mw};
      checks++;
      if (st_got !== st_exp) begin
         errors++;
         $display("FAIL %s access status got %b exp %b", tag, st_got, st_exp);
      end
      checks++;
      if ({o_mem_adr, o_mem_dtype} !== {a, dt}) begin
         errors++;
         $display("FAIL %s access adr got %h/%b exp %h/%b", tag, o_mem_adr, o_mem_dtype,
                  a, dt);
      end
      if (!rd) begin
         checks++;
         if (o_mem_wdata !== wd) begin
            errors++;
            $display("FAIL %s access wdata got %h exp %h", tag, o_mem_wdata, wd);
         end
      end
      rd_exp = mem_rd(a);

      // Request fields change after acceptance and must be ignored
      cpu_adr = rnd64(); cpu_wdata = rnd64(); cpu_memwrite = 2'($urandom);
      cpu_dtype = 1'($urandom);
      ldr_adr = rnd64(); ldr_wdata = rnd64(); ldr_memwrite = 2'($urandom);
      ldr_dtype = 1'($urandom);

      if (rd) begin
         for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            st_got = {o_busy, o_owner, o_cpu_ready, o_ldr_ready, o_mem_memwrite};
            st_exp = {1'b1, g, 4'b0000};
            checks++;
            if (st_got !== st_exp || o_mem_adr !== a || o_mem_dtype !== dt) begin
               errors++;
               $display("FAIL %s wait%0d status %b adr %h exp %b adr %h", tag, i, st_got,
                        o_mem_adr, st_exp, a);
            end
         end
         if (g) exp_ldr = rd_exp;
         else   exp_cpu = rd_exp;
      end

      @(negedge clk);  // response cycle
      st_got = {o_busy, o_owner, o_cpu_ready, o_ldr_ready, o_mem_memwrite};
      st_exp = {1'b1, g, !g, g, 2'b00};
      checks++;
      if (st_got !== st_exp) begin
         errors++;
         $display("FAIL %s resp status got %b exp %b", tag, st_got, st_exp);
      end
      checks++;
      if (o_cpu_rdata !== exp_cpu || o_ldr_rdata !== exp_ldr) begin
         errors++;
         $display("FAIL %s rdata got cpu %h ldr %h exp cpu %h ldr %h", tag, o_cpu_rdata,
                  o_ldr_rdata, exp_cpu, exp_ldr);
      end
      if (!hold) begin
         cpu_req = 1'b0;
         ldr_req = 1'b0;
      end
      @(negedge clk);  // back in idle
   endtask

   task automatic test_reset(input bit which);
      logic [5:0] st_got;
      cpu_req = 1'b0; ldr_req = 1'b0;
      reset = 1'b1;
      sel = which;
      repeat (2) @(posedge clk);
      @(negedge clk);
      st_got = {o_busy, o_owner, o_cpu_ready, o_ldr_ready, o_mem_memwrite};
      checks++;
      if (st_got !== 6'b010000) begin
         errors++;
         $display("FAIL reset%0d status got %b exp 010000", which, st_got);
      end
      checks++;
      if ({o_cpu_rdata, o_ldr_rdata, o_mem_adr, o_mem_wdata, o_mem_dtype} !== '0) begin
         errors++;
         $display("FAIL reset%0d data got %h %h %h %h exp zero", which, o_cpu_rdata,
                  o_ldr_rdata, o_mem_adr, o_mem_wdata);
      end
      reset = 1'b0;
      m_owner = 1'b1;
      exp_cpu = '0;
      exp_ldr = '0;
      lat = which ? 3 : 1;
   endtask

   task automatic test_idle();
      logic [5:0] st_got;
      repeat (3) begin
         @(negedge clk);
         st_got = {o_busy, o_owner, o_cpu_ready, o_ldr_ready, o_mem_memwrite};
         checks++;
         if (st_got !== {1'b0, m_owner, 4'b0000}) begin
            errors++;
            $display("FAIL idle status got %b exp %b", st_got, {1'b0, m_owner, 4'b0000});
         end
      end
   endtask

   task automatic test_cpu_read();
      bit o;
      mem_arr[64'h40] = 64'hDEAD_BEEF;
      do_txn("cpu_read", 1'b1, 1'b0, 64'h40, rnd64(), 2'b00, 1'b1,
             rnd64(), rnd64(), 2'b00, 1'b0, 1'b0, o);
      checks++;
      if (o_cpu_rdata !== 64'hDEAD_BEEF || o_ldr_rdata !== 64'h0) begin
         errors++;
         $display("FAIL cpu_read value got %h ldr %h exp deadbeef ldr 0", o_cpu_rdata,
                  o_ldr_rdata);
      end
   endtask

   task automatic test_ldr_write();
      bit o;
      do_txn("ldr_write", 1'b0, 1'b1, rnd64(), rnd64(), 2'b00, 1'b0,
             64'h80, 64'h1234, 2'b01, 1'b0, 1'b0, o);
      checks++;
      if (mem_rd(64'h80) !== 64'h1234) begin
         errors++;
         $display("FAIL ldr_write mem got %h exp 1234", mem_rd(64'h80));
      end
   endtask

   task automatic test_tie();
      bit         o;
      logic [3:0] order, exp_order;
`ifdef MEM_ARB_CPU_PRIO_EN
      exp_order = 4'b0000;
`else
      exp_order = 4'b1010;  // cpu, ldr, cpu, ldr (bit 0 first)
`endif
      for (int i = 0; i < 4; i++) begin
         do_txn("tie", 1'b1, 1'b1, 64'h100 + 64'(i * 8), rnd64(), 2'b00, 1'b0,
                64'h140 + 64'(i * 8), rnd64(), 2'(i[0]), 1'b1, 1'b1, o);
         order[i] = o;
      end
      cpu_req = 1'b0;
      ldr_req = 1'b0;
      checks++;
      if (order !== exp_order) begin
         errors++;
         $display("FAIL tie grant order got %b exp %b", order, exp_order);
      end
   endtask

   task automatic test_random(input int n);
      bit         o;
      int         kind;
      logic [1:0] cmw, lmw;
      for (int i = 0; i < n; i++) begin
         kind = $urandom_range(1, 3);
         cmw  = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
         lmw  = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
         do_txn("random", kind != 2, kind != 1,
                64'h200 + 64'($urandom_range(0, 15) * 8), rnd64(), cmw, 1'($urandom),
                64'h200 + 64'($urandom_range(0, 15) * 8), rnd64(), lmw, 1'($urandom),
                1'b0, o);
         if ($urandom_range(0, 3) == 0) @(negedge clk);
      end
   endtask

   task automatic test_late_change();
      bit o;
      do_txn("late_change", 1'b1, 1'b0, 64'h40, rnd64(), 2'b00, 1'b0,
             rnd64(), rnd64(), 2'b00, 1'b0, 1'b0, o);
      checks++;
      if (o_cpu_rdata !== 64'hDEAD_BEEF) begin
         errors++;
         $display("FAIL late_change value got %h exp deadbeef", o_cpu_rdata);
      end
   endtask

   task automatic test_reset_mid_wait();
      logic [5:0] st_got;
      cpu_req = 1'b0;
      ldr_req = 1'b1; ldr_adr = 64'h300; ldr_memwrite = 2'b00; ldr_dtype = 1'b0;
      @(negedge clk);  // access
      @(negedge clk);  // first wait cycle
      ldr_req = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      m_owner = 1'b1;
      exp_cpu = '0;
      exp_ldr = '0;
      st_got = {o_busy, o_owner, o_cpu_ready, o_ldr_ready, o_mem_memwrite};
      checks++;
      if (st_got !== 6'b010000) begin
         errors++;
         $display("FAIL midwait status got %b exp 010000", st_got);
      end
      checks++;
      if ({o_ldr_rdata, o_cpu_rdata, o_mem_adr} !== '0) begin
         errors++;
         $display("FAIL midwait data got ldr %h cpu %h adr %h exp zero", o_ldr_rdata,
                  o_cpu_rdata, o_mem_adr);
      end
      repeat (5) begin
         @(negedge clk);
         st_got = {o_busy, o_owner, o_cpu_ready, o_ldr_ready, o_mem_memwrite};
         checks++;
         if (st_got !== 6'b010000) begin
            errors++;
            $display("FAIL midwait after status got %b exp 010000", st_got);
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; sel = 1'b0;
      cpu_req = 1'b0; cpu_adr = '0; cpu_wdata = '0; cpu_memwrite = 2'b00; cpu_dtype = 1'b0;
      ldr_req = 1'b0; ldr_adr = '0; ldr_wdata = '0; ldr_memwrite = 2'b00; ldr_dtype = 1'b0;
      lat = 1; m_owner = 1'b1; exp_cpu = '0; exp_ldr = '0;
      @(negedge clk);

      test_reset(1'b0);
      test_idle();
      test_cpu_read();
      test_ldr_write();
      test_tie();
      test_random(30);

      test_reset(1'b1);
      test_tie();
      test_late_change();
      test_random(30);
      test_reset_mid_wait();
      test_random(10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
